// File: rtl/irq_pending_unit_pkg.sv
// +--------------------------------------------------------------------+
// | irq_pkg : shared types and defaults for the IRQ pending front end   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package irq_pkg;
    localparam int IRQ_N            = 16;
    localparam int IRQ_SYNC_DEFAULT = 2;

    typedef logic [IRQ_N-1:0] irq_vec_t;
endpackage

`default_nettype wire

// File: rtl/irq_pending_unit_if.sv
// +--------------------------------------------------------------------+
// | irq_pending_unit_if : request/mask/clear bundle of the pending unit |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface irq_pending_unit_if
    import irq_pkg::*;
#(
    parameter int N = IRQ_N
);
    logic [N-1:0] irq_req_i;
    logic [N-1:0] mask_i;
    logic [N-1:0] irq_ret_i;
    logic [N-1:0] ovr_clr_i;
    logic [N-1:0] masked_irq_o;
    logic [N-1:0] pending_o;
    logic [N-1:0] overrun_o;

    modport slave (
        input  irq_req_i, mask_i, irq_ret_i, ovr_clr_i,
        output masked_irq_o, pending_o, overrun_o
    );

    modport master (
        output irq_req_i, mask_i, irq_ret_i, ovr_clr_i,
        input  masked_irq_o, pending_o, overrun_o
    );
endinterface

`default_nettype wire

// File: rtl/irq_pending_unit_sync.sv
// +--------------------------------------------------------------------+
// | irq_sync : WIDTH-bit, STAGES-deep async-reset synchroniser          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module irq_sync
    import irq_pkg::*;
#(
    parameter int WIDTH  = IRQ_N,
    parameter int STAGES = IRQ_SYNC_DEFAULT
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    input  wire logic [WIDTH-1:0] d_i,
    output logic      [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int s = 1; s < STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];
endmodule

`default_nettype wire

// File: rtl/irq_pending_unit.sv
// +--------------------------------------------------------------------+
// | irq_pending_unit : sync, edge/level detect, pending, overrun, mask  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module irq_pending_unit
    import irq_pkg::*;
#(
    parameter int               N_IRQ       = IRQ_N,
    parameter int               SYNC_STAGES = IRQ_SYNC_DEFAULT,
    parameter logic [N_IRQ-1:0] EDGE_MASK   = '0
) (
    input  wire logic         clk_i,
    input  wire logic         rst_ni,
    irq_pending_unit_if.slave bus
);
    logic [N_IRQ-1:0] sync_w;
    logic [N_IRQ-1:0] rise_w;
    logic [N_IRQ-1:0] prev_q;
    logic [N_IRQ-1:0] pending_q;
    logic [N_IRQ-1:0] pending_d;
    logic [N_IRQ-1:0] overrun_q;
    logic [N_IRQ-1:0] overrun_d;

    irq_sync #(
        .WIDTH  (N_IRQ),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (bus.irq_req_i),
        .q_o    (sync_w)
    );

    assign rise_w = sync_w & ~prev_q & EDGE_MASK;

    // Edge lines: a new edge beats a same-cycle clear; level lines just follow sync.
    always_comb begin
        pending_d = ((rise_w | (pending_q & ~bus.irq_ret_i)) & EDGE_MASK)
                  | (sync_w & ~EDGE_MASK);
        overrun_d = ((rise_w & pending_q & ~bus.irq_ret_i)
                  |  (overrun_q & ~bus.ovr_clr_i)) & EDGE_MASK;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q    <= '0;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            prev_q    <= sync_w;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.pending_o    = pending_q;
    assign bus.overrun_o    = overrun_q;
    assign bus.masked_irq_o = pending_q & bus.mask_i;
endmodule

`default_nettype wire

// File: tb/tb_irq_pending_unit.sv
// Bench for irq_pending_unit: directed scenarios on the 2-stage instance,
// randomized traffic on 2- and 4-stage instances against a delay-line model.
`default_nettype none

module tb_irq_pending_unit;
    localparam logic [15:0] EM = 16'h0F0B;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] irq_req = '0;
    logic [15:0] mask    = 16'hFFFF;
    logic [15:0] irq_ret = '0;
    logic [15:0] ovr_clr = '0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    irq_pending_unit_if #(.N(16)) if2 ();
    irq_pending_unit_if #(.N(16)) if4 ();

    assign if2.irq_req_i = irq_req;
    assign if2.mask_i    = mask;
    assign if2.irq_ret_i = irq_ret;
    assign if2.ovr_clr_i = ovr_clr;
    assign if4.irq_req_i = irq_req;
    assign if4.mask_i    = mask;
    assign if4.irq_ret_i = irq_ret;
    assign if4.ovr_clr_i = ovr_clr;

    irq_pending_unit #(.N_IRQ(16), .SYNC_STAGES(2), .EDGE_MASK(EM)) u_dut2 (
        .clk_i (clk), .rst_ni (rst_n), .bus (if2)
    );
    irq_pending_unit #(.N_IRQ(16), .SYNC_STAGES(4), .EDGE_MASK(EM)) u_dut4 (
        .clk_i (clk), .rst_ni (rst_n), .bus (if4)
    );

    logic [15:0] o_pend [2];
    logic [15:0] o_mirq [2];
    logic [15:0] o_ovr  [2];
    assign o_pend[0] = if2.pending_o;
    assign o_mirq[0] = if2.masked_irq_o;
    assign o_ovr[0]  = if2.overrun_o;
    assign o_pend[1] = if4.pending_o;
    assign o_mirq[1] = if4.masked_irq_o;
    assign o_ovr[1]  = if4.overrun_o;

    // Reference model: hist[d][j] is the raw line value sampled j clocks ago.
    logic [15:0] hist   [2][6];
    logic [15:0] m_pend [2];
    logic [15:0] m_ovr  [2];
    int          ms;
    logic        m_rise;
    logic        m_oset;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int j = 0; j < 6; j++) hist[d][j] = '0;
                m_pend[d] = '0;
                m_ovr[d]  = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                ms = 2 + 2 * d;
                for (int j = 5; j > 0; j--) hist[d][j] = hist[d][j-1];
                hist[d][0] = irq_req;
                for (int i = 0; i < 16; i++) begin
                    if (EM[i]) begin
                        m_rise = hist[d][ms][i] && !hist[d][ms+1][i];
                        m_oset = m_rise && m_pend[d][i] && !irq_ret[i];
                        if (m_rise)          m_pend[d][i] = 1'b1;
                        else if (irq_ret[i]) m_pend[d][i] = 1'b0;
                        if (m_oset)          m_ovr[d][i] = 1'b1;
                        else if (ovr_clr[i]) m_ovr[d][i] = 1'b0;
                    end else begin
                        m_pend[d][i] = hist[d][ms][i];
                        m_ovr[d][i]  = 1'b0;
                    end
                end
            end
        end
    end

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; irq_req = '0; mask = 16'hFFFF; irq_ret = '0; ovr_clr = '0;
        nclk(3);
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if (o_pend[d] !== 16'h0) begin n_err++; $display("FAIL rst_pend[%0d] got=%h exp=0000", d, o_pend[d]); end
            n_cmp++; if (o_mirq[d] !== 16'h0) begin n_err++; $display("FAIL rst_mirq[%0d] got=%h exp=0000", d, o_mirq[d]); end
            n_cmp++; if (o_ovr[d]  !== 16'h0) begin n_err++; $display("FAIL rst_ovr[%0d] got=%h exp=0000", d, o_ovr[d]); end
        end
        rst_n = 1'b1;
        nclk(2);
        n_cmp++; if (if2.pending_o !== 16'h0) begin n_err++; $display("FAIL rst_rel_pend got=%h exp=0000", if2.pending_o); end
    endtask

    task automatic test_edge_latency();
        irq_req = 16'h0001;
        nclk(1);
        n_cmp++; if (if2.masked_irq_o !== 16'h0) begin n_err++; $display("FAIL lat_c1 got=%h exp=0000", if2.masked_irq_o); end
        nclk(1);
        n_cmp++; if (if2.masked_irq_o !== 16'h0) begin n_err++; $display("FAIL lat_c2 got=%h exp=0000", if2.masked_irq_o); end
        irq_req = '0;
        nclk(1);
        n_cmp++; if (if2.masked_irq_o !== 16'h0001) begin n_err++; $display("FAIL lat_c3 got=%h exp=0001", if2.masked_irq_o); end
        nclk(2);
        n_cmp++; if (if2.masked_irq_o !== 16'h0001) begin n_err++; $display("FAIL lat_hold got=%h exp=0001", if2.masked_irq_o); end
        irq_ret = 16'h0001;
        nclk(1);
        irq_ret = '0;
        n_cmp++; if (if2.masked_irq_o !== 16'h0) begin n_err++; $display("FAIL lat_ret got=%h exp=0000", if2.masked_irq_o); end
    endtask

    task automatic test_overrun();
        irq_req = 16'h0001; nclk(2);
        irq_req = '0;       nclk(2);
        n_cmp++; if (if2.overrun_o !== 16'h0) begin n_err++; $display("FAIL ovr_pre got=%h exp=0000", if2.overrun_o); end
        irq_req = 16'h0001; nclk(2);
        irq_req = '0;       nclk(1);
        n_cmp++; if (if2.overrun_o !== 16'h0001) begin n_err++; $display("FAIL ovr_set got=%h exp=0001", if2.overrun_o); end
        n_cmp++; if (if2.pending_o !== 16'h0001) begin n_err++; $display("FAIL ovr_pend got=%h exp=0001", if2.pending_o); end
        ovr_clr = 16'h0001; nclk(1);
        ovr_clr = '0;
        n_cmp++; if (if2.overrun_o !== 16'h0) begin n_err++; $display("FAIL ovr_clr got=%h exp=0000", if2.overrun_o); end
        n_cmp++; if (if2.pending_o !== 16'h0001) begin n_err++; $display("FAIL ovr_clr_pend got=%h exp=0001", if2.pending_o); end
        irq_ret = 16'h0001; nclk(1);
        irq_ret = '0;
        n_cmp++; if (if2.pending_o !== 16'h0) begin n_err++; $display("FAIL ovr_ret got=%h exp=0000", if2.pending_o); end
    endtask

    task automatic test_set_wins();
        irq_req = 16'h0001; nclk(2);
        irq_req = '0;       nclk(1);
        n_cmp++; if (if2.pending_o !== 16'h0001) begin n_err++; $display("FAIL sw_pre got=%h exp=0001", if2.pending_o); end
        irq_req = 16'h0001; nclk(2);
        irq_req = '0; irq_ret = 16'h0001; nclk(1);
        irq_ret = '0;
        n_cmp++; if (if2.pending_o !== 16'h0001) begin n_err++; $display("FAIL sw_pend got=%h exp=0001", if2.pending_o); end
        n_cmp++; if (if2.overrun_o !== 16'h0) begin n_err++; $display("FAIL sw_ovr got=%h exp=0000", if2.overrun_o); end
        irq_ret = 16'h0001; nclk(1);
        irq_ret = '0;
        n_cmp++; if (if2.pending_o !== 16'h0) begin n_err++; $display("FAIL sw_ret got=%h exp=0000", if2.pending_o); end
    endtask

    task automatic test_level();
        mask = 16'hFFDF; irq_ret = 16'h0020; irq_req = 16'h0020;
        nclk(2);
        n_cmp++; if (if2.pending_o !== 16'h0) begin n_err++; $display("FAIL lvl_c2 got=%h exp=0000", if2.pending_o); end
        nclk(1);
        n_cmp++; if (if2.pending_o !== 16'h0020) begin n_err++; $display("FAIL lvl_pend got=%h exp=0020", if2.pending_o); end
        n_cmp++; if (if2.masked_irq_o !== 16'h0) begin n_err++; $display("FAIL lvl_masked got=%h exp=0000", if2.masked_irq_o); end
        mask = 16'hFFFF;
        #1;
        n_cmp++; if (if2.masked_irq_o !== 16'h0020) begin n_err++; $display("FAIL lvl_unmask got=%h exp=0020", if2.masked_irq_o); end
        nclk(1);
        irq_req = '0;
        nclk(2);
        n_cmp++; if (if2.pending_o !== 16'h0020) begin n_err++; $display("FAIL lvl_hold got=%h exp=0020", if2.pending_o); end
        nclk(1);
        n_cmp++; if (if2.pending_o !== 16'h0) begin n_err++; $display("FAIL lvl_drop got=%h exp=0000", if2.pending_o); end
        n_cmp++; if (if2.overrun_o !== 16'h0) begin n_err++; $display("FAIL lvl_ovr got=%h exp=0000", if2.overrun_o); end
        irq_ret = '0;
    endtask

    task automatic test_reset_mid();
        irq_req = 16'h0008;
        nclk(4);
        n_cmp++; if (if2.pending_o !== 16'h0008) begin n_err++; $display("FAIL rm_pre got=%h exp=0008", if2.pending_o); end
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if (o_pend[d] !== 16'h0) begin n_err++; $display("FAIL rm_pend[%0d] got=%h exp=0000", d, o_pend[d]); end
            n_cmp++; if (o_mirq[d] !== 16'h0) begin n_err++; $display("FAIL rm_mirq[%0d] got=%h exp=0000", d, o_mirq[d]); end
            n_cmp++; if (o_ovr[d]  !== 16'h0) begin n_err++; $display("FAIL rm_ovr[%0d] got=%h exp=0000", d, o_ovr[d]); end
        end
        nclk(2);
        rst_n = 1'b1;
        nclk(2);
        n_cmp++; if (if2.pending_o !== 16'h0) begin n_err++; $display("FAIL rm_r2 got=%h exp=0000", if2.pending_o); end
        nclk(1);
        n_cmp++; if (if2.pending_o !== 16'h0008) begin n_err++; $display("FAIL rm_r3 got=%h exp=0008", if2.pending_o); end
        nclk(1);
        n_cmp++; if (if4.pending_o !== 16'h0) begin n_err++; $display("FAIL rm4_r4 got=%h exp=0000", if4.pending_o); end
        nclk(1);
        n_cmp++; if (if4.pending_o !== 16'h0008) begin n_err++; $display("FAIL rm4_r5 got=%h exp=0008", if4.pending_o); end
        irq_req = '0;
    endtask

    task automatic test_random(input int cycles);
        logic [15:0] flip;
        rst_n = 1'b0; irq_req = '0; irq_ret = '0; ovr_clr = '0; mask = 16'hFFFF;
        nclk(2);
        rst_n = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            nclk(1);
            for (int d = 0; d < 2; d++) begin
                n_cmp++; if (o_pend[d] !== m_pend[d]) begin n_err++; $display("FAIL rnd_pend[%0d] cyc=%0d got=%h exp=%h", d, c, o_pend[d], m_pend[d]); end
                n_cmp++; if (o_mirq[d] !== (m_pend[d] & mask)) begin n_err++; $display("FAIL rnd_mirq[%0d] cyc=%0d got=%h exp=%h", d, c, o_mirq[d], m_pend[d] & mask); end
                n_cmp++; if (o_ovr[d] !== m_ovr[d]) begin n_err++; $display("FAIL rnd_ovr[%0d] cyc=%0d got=%h exp=%h", d, c, o_ovr[d], m_ovr[d]); end
            end
            if (c == cycles / 2) begin
                #2 rst_n = 1'b0;
                nclk(1);
                rst_n = 1'b1;
            end
            flip = '0;
            for (int i = 0; i < 16; i++) flip[i] = ($urandom_range(0, 4) == 0);
            irq_req = irq_req ^ flip;
            irq_ret = ($urandom_range(0, 2) == 0) ? (16'h0001 << $urandom_range(0, 15)) : 16'h0;
            ovr_clr = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'h0;
            if ($urandom_range(0, 3) == 0) mask = 16'($urandom);
        end
        irq_req = '0; irq_ret = '0; ovr_clr = '0; mask = 16'hFFFF;
    endtask

    initial begin
        test_reset();
        test_edge_latency();
        test_overrun();
        test_set_wins();
        test_level();
        test_reset_mid();
        test_random(600);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
